ifu_prefetch_buf: RTL and testbench



---
 rtl/ifu_prefetch_buf_pkg.sv | 17 +
 rtl/ifu_pf_fifo.sv | 63 ++++++
 rtl/ifu_prefetch_buf.sv | 125 ++++++++++++
 tb/tb_ifu_prefetch_buf.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_buf_pkg.sv
// Shared constants and FSM state encoding for the instruction prefetch buffer.
package ifu_prefetch_buf_pkg;

    // Bytes per instruction word; the fetch PC advances by this amount.
    localparam int INS_BYTES = 4;

    // Canonical NOP (addi x0, x0, 0) that IF/ID inserts on a flush.
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        PF_FETCH   = 2'd0,  // no request outstanding
        PF_WAIT    = 2'd1,  // waiting for a response to be kept
        PF_DISCARD = 2'd2   // waiting for a response to be dropped
    } pf_state_e;

endpackage

// File: rtl/ifu_pf_fifo.sv
// Synchronous FIFO holding fetched {addr, ins} entries.
// The head entry is read combinationally so it is visible the cycle after it is
// pushed; DEPTH is small, so the array maps to distributed RAM / registers.
module ifu_pf_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push && (count_reg != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    // Storage write; no reset so the array stays a plain memory.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !srst) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Instruction-fetch front end: one outstanding ROM request, a DEPTH-entry
// prefetch FIFO drained to IF/ID via valid/ready, and jump flush handling.
// Optional macro IFU_PREFETCH_BYPASS_EN presents a response combinationally
// when the FIFO is empty, saving one cycle of fetch-to-issue latency.
module ifu_prefetch_buf
    import ifu_prefetch_buf_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INS_W     = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rest,
    output logic                       rom_req_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic                       rom_gnt_i,
    input  logic                       rom_rvalid_i,
    input  logic [INS_W-1:0]           rom_rdata_i,
    input  logic                       jump_en_i,
    input  logic [ADDR_W-1:0]          jump_addr_i,
    output logic                       ins_valid_o,
    input  logic                       ins_ready_i,
    output logic [INS_W-1:0]           ins_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int LVL_W = $clog2(DEPTH+1);

    pf_state_e                 state_reg, state_next;
    logic [ADDR_W-1:0]         pc_reg, pc_next;
    logic [ADDR_W-1:0]         req_pc_reg, req_pc_next;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [LVL_W-1:0]          fifo_count;
    logic [ADDR_W+INS_W-1:0]   fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      bypass_hit;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == LVL_W'(DEPTH));

`ifdef IFU_PREFETCH_BYPASS_EN
    // Response forwarded straight to IF/ID when nothing is queued ahead of it.
    assign bypass_hit = !rest && !jump_en_i && fifo_empty
                        && (state_reg == PF_WAIT) && rom_rvalid_i;
`else
    assign bypass_hit = 1'b0;
`endif

    // In FETCH nothing is outstanding, so a free slot guarantees room for the reply.
    assign rom_req_o   = !rest && (state_reg == PF_FETCH) && !fifo_full;
    assign rom_addr_o  = pc_reg;
    assign ins_valid_o = !rest && (!fifo_empty || bypass_hit);
    assign ins_o       = bypass_hit ? rom_rdata_i : fifo_head[INS_W-1:0];
    assign addr_o      = bypass_hit ? req_pc_reg  : fifo_head[ADDR_W+INS_W-1:INS_W];
    assign level_o     = rest ? '0 : fifo_count;

    // A jump flushes the queue, so it also blocks the consumer's pop.
    assign fifo_pop = ins_ready_i && !fifo_empty && !jump_en_i;

    // Next-state, pc and push decision; a jump overrides pc and suppresses push.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        fifo_push   = 1'b0;
        case (state_reg)
            PF_FETCH: begin
                if (rom_req_o && rom_gnt_i) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + ADDR_W'(INS_BYTES);
                    state_next  = jump_en_i ? PF_DISCARD : PF_WAIT;
                end
            end
            PF_WAIT: begin
                if (rom_rvalid_i) begin
                    state_next = PF_FETCH;
                    fifo_push  = !jump_en_i && !(bypass_hit && ins_ready_i);
                end else if (jump_en_i) begin
                    state_next = PF_DISCARD;
                end
            end
            PF_DISCARD: begin
                if (rom_rvalid_i) begin
                    state_next = PF_FETCH;
                end
            end
            default: state_next = PF_FETCH;
        endcase
        if (jump_en_i) begin
            pc_next = {jump_addr_i[ADDR_W-1:2], 2'b00};
        end
    end

    // FSM and fetch address registers.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_reg  <= PF_FETCH;
            pc_reg     <= BOOT_ADDR;
            req_pc_reg <= BOOT_ADDR;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_pc_reg <= req_pc_next;
        end
    end

    ifu_pf_fifo #(
        .WIDTH (ADDR_W + INS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rest),
        .clear (jump_en_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({req_pc_reg, rom_rdata_i}),
        .rdata (fifo_head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Self-checking bench for ifu_prefetch_buf: ROM model with programmable
// latency, scoreboard of expected {addr, ins} in fetch order, flush tracking.
module tb_ifu_prefetch_buf;

    localparam int          ADDR_W = 32;
    localparam int          INS_W  = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BOOT   = 32'h0;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b1;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = 32'h0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        ins_valid_o;
    logic        ins_ready_i = 1'b1;
    logic [31:0] ins_o;
    logic [31:0] addr_o;
    logic [2:0]  level_o;

    ifu_prefetch_buf #(
        .ADDR_W(ADDR_W), .INS_W(INS_W), .DEPTH(DEPTH), .BOOT_ADDR(BOOT)
    ) dut (
        .clk(clk), .rest(rest),
        .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
        .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ins_valid_o(ins_valid_o), .ins_ready_i(ins_ready_i),
        .ins_o(ins_o), .addr_o(addr_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ROM model state
    int          rom_lat = 1;
    bit          pending = 0;
    bit          stale   = 0;
    int          timer   = 0;
    logic [31:0] resp_addr = '0;

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch = BOOT;
    logic [31:0] exp_issue = BOOT;

    // Per-cycle samples
    bit          s_req, s_valid, s_hs, s_gnt, s_rvalid;
    logic [31:0] s_addr, s_hs_addr, s_gnt_addr;
    logic [2:0]  s_level;
    int          hs_total = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic drive_rom();
        if (pending && timer > 0) timer--;
        rom_rvalid_i = pending && (timer == 0);
        rom_rdata_i  = rom_rvalid_i ? rom_word(resp_addr) : 32'hDEAD_BEEF;
        rom_gnt_i    = 1'b1;
    endtask

    // One clock: sample/check at negedge, then advance inputs after posedge.
    task automatic cycle();
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        s_req = rom_req_o; s_addr = rom_addr_o; s_valid = ins_valid_o;
        s_level = level_o; s_rvalid = rom_rvalid_i; s_hs = 0; s_gnt = 0;
        if (rest) begin
            n_tests++;
            if (rom_req_o !== 1'b0 || ins_valid_o !== 1'b0 || level_o !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: req=%b valid=%b level=%0d, required 0 0 0",
                         rom_req_o, ins_valid_o, level_o);
            end
            exp_q.delete();
            exp_fetch = BOOT; exp_issue = BOOT;
            if (pending) stale = 1;
            if (rom_rvalid_i) begin pending = 0; stale = 0; end
        end else begin
            if (rom_rvalid_i) begin
                if (!jump_en_i && !stale) begin
                    exp_q.push_back({exp_issue, rom_word(exp_issue)});
                    exp_issue += 32'd4;
                end
                pending = 0; stale = 0;
            end
            if (!jump_en_i && ins_valid_o && ins_ready_i) begin
                s_hs = 1; s_hs_addr = addr_o; hs_total++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected: got addr=%h ins=%h, required no issue", addr_o, ins_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({addr_o, ins_o} !== e) begin
                        n_fail++;
                        $display("FAIL issue_data: got addr=%h ins=%h, required addr=%h ins=%h",
                                 addr_o, ins_o, e[63:32], e[31:0]);
                    end else
                        $display("[TB] cyc %0d issue addr=%h ins=%h", cyc, addr_o, ins_o);
                end
            end
            if (rom_req_o && rom_gnt_i) begin
                n_tests++;
                if (rom_addr_o !== exp_fetch || pending) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %h (outstanding=%b), required %h with none outstanding",
                             rom_addr_o, pending, exp_fetch);
                end
                s_gnt = 1; s_gnt_addr = rom_addr_o;
                pending = 1; timer = rom_lat; resp_addr = rom_addr_o; stale = 0;
                exp_fetch += 32'd4;
            end
            if (jump_en_i) begin
                exp_q.delete();
                exp_fetch = {jump_addr_i[31:2], 2'b00};
                exp_issue = exp_fetch;
                if (pending) stale = 1;
            end
        end
        @(posedge clk);
        #1;
        jump_en_i = 1'b0;
        drive_rom();
    endtask

    task automatic apply_reset(input int n);
        rest = 1'b1;
        repeat (n) cycle();
        rest = 1'b0;
    endtask

    task automatic wait_gnt(input string tag);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            got = s_gnt;
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no grant seen, required one within 30 cycles", tag);
        end
    endtask

    task automatic check_first_issue(input string tag, input logic [31:0] want);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            got = s_hs;
        end
        n_tests++;
        if (!got || s_hs_addr !== want) begin
            n_fail++;
            $display("FAIL %s: first issue seen=%b addr=%h, required addr=%h", tag, got, s_hs_addr, want);
        end
    endtask

    task automatic test_reset();
        rom_lat = 1; ins_ready_i = 1'b1;
        apply_reset(3);
        cycle();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== BOOT) begin
            n_fail++;
            $display("FAIL reset_first_fetch: req=%b addr=%h, required 1 %h", s_req, s_addr, BOOT);
        end
    endtask

    task automatic test_stream();
        int hs = 0, last = -1, max_gap = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (s_hs) begin
                if (last >= 0 && cyc - last > max_gap) max_gap = cyc - last;
                last = cyc; hs++;
            end
        end
        n_tests++;
        if (hs < 11 || max_gap > 2) begin
            n_fail++;
            $display("FAIL stream_rate: issued=%0d max_gap=%0d, required >=11 and <=2", hs, max_gap);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0, hs0;
        rom_lat = 1;
        apply_reset(2);
        ins_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_level == 3'd4 && s_req) bad++;
        end
        n_tests++;
        if (s_level !== 3'd4 || s_req !== 1'b0 || bad != 0) begin
            n_fail++;
            $display("FAIL bp_full: level=%0d req=%b req_at_full=%0d, required 4 0 0", s_level, s_req, bad);
        end
        ins_ready_i = 1'b1;
        hs0 = hs_total;
        wait_gnt("bp_resume");
        n_tests++;
        if (s_gnt_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL bp_resume_addr: got %h, required 00000010", s_gnt_addr);
        end
        repeat (8) cycle();
        n_tests++;
        if (hs_total - hs0 < 5) begin
            n_fail++;
            $display("FAIL bp_drain: issued=%0d, required >=5", hs_total - hs0);
        end
    endtask

    task automatic test_jump_wait();
        rom_lat = 3;
        wait_gnt("jw");
        jump_en_i = 1'b1; jump_addr_i = 32'h103;
        cycle();
        cycle();
        n_tests++;
        if (s_valid !== 1'b0 || s_level !== 3'd0 || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL jw_flush: valid=%b level=%0d req=%b, required 0 0 0", s_valid, s_level, s_req);
        end
        check_first_issue("jw_first", 32'h100);
    endtask

    task automatic test_jump_rvalid_gnt();
        bit hit = 0;
        rom_lat = 2;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (rom_rvalid_i) hit = 1; else cycle();
        end
        jump_en_i = 1'b1; jump_addr_i = 32'h200;
        cycle();
        cycle();
        n_tests++;
        if (!hit || s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL jr_redirect: hit=%b valid=%b req=%b addr=%h, required 1 0 1 00000200",
                     hit, s_valid, s_req, s_addr);
        end
        check_first_issue("jr_first", 32'h200);
        rom_lat = 1; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (rom_req_o) hit = 1; else cycle();
        end
        jump_en_i = 1'b1; jump_addr_i = 32'h300;
        cycle();
        cycle();
        n_tests++;
        if (!hit || s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL jg_discard: hit=%b valid=%b req=%b, required 1 0 0", hit, s_valid, s_req);
        end
        check_first_issue("jg_first", 32'h300);
    endtask

    task automatic test_reset_mid();
        rom_lat = 2;
        wait_gnt("rm");
        rest = 1'b1;
        cycle();
        rest = 1'b0;
        cycle();
        n_tests++;
        if (!s_rvalid || !s_gnt || s_gnt_addr !== BOOT || s_level !== 3'd0) begin
            n_fail++;
            $display("FAIL rm_restart: rvalid=%b gnt=%b addr=%h level=%0d, required 1 1 %h 0",
                     s_rvalid, s_gnt, s_gnt_addr, s_level, BOOT);
        end
        check_first_issue("rm_first", BOOT);
    endtask

    task automatic test_latency();
        rom_lat = 1; ins_ready_i = 1'b1;
        apply_reset(2);
        cycle();
        cycle();
`ifdef IFU_PREFETCH_BYPASS_EN
        n_tests++;
        if (!s_rvalid || s_valid !== 1'b1 || s_level !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rvalid=%b valid=%b level=%0d, required 1 1 0",
                     s_rvalid, s_valid, s_level);
        end
        cycle();
        n_tests++;
        if (s_level !== 3'd0) begin
            n_fail++;
            $display("FAIL bypass_level: level=%0d, required 0", s_level);
        end
`else
        n_tests++;
        if (!s_rvalid || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_latency_rv: rvalid=%b valid=%b, required 1 0", s_rvalid, s_valid);
        end
        cycle();
        n_tests++;
        if (s_valid !== 1'b1 || s_level !== 3'd1) begin
            n_fail++;
            $display("FAIL fifo_latency_next: valid=%b level=%0d, required 1 1", s_valid, s_level);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_wait();
        test_jump_rvalid_gnt();
        test_reset_mid();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end

endmodule
